// File: rtl/dmem_mmio_responder.sv
// Data-memory responder: word RAM, free-running cycle counter and a FIFO-fed UART transmitter.
// Define UART_PARITY_EN to add an even-parity bit to every frame (reported in STATUS bit4).
module dmem_mmio_responder #(
   parameter int RAM_WORDS    = 256,
   parameter int FIFO_DEPTH   = 8,
   parameter int CLKS_PER_BIT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        memwrite,
   input  logic [31:0] addr,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic        uart_tx
);
   localparam int RAM_AW = $clog2(RAM_WORDS);
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = $clog2(CLKS_PER_BIT);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef UART_PARITY_EN
      PARITY,
`endif
      STOP
   } txState_t;

`ifdef UART_PARITY_EN
   localparam logic PARITY_FLAG = 1'b1;
`else
   localparam logic PARITY_FLAG = 1'b0;
`endif

   // Address decode; the two byte-offset bits play no part in word accesses
   logic              isRam, isTxData, isStatus, isCycles;
   logic [RAM_AW-1:0] ramIdx;
   logic              unusedAddrBits;

   assign isRam          = (addr[31:16] == 16'h0) && (32'(addr[15:2]) < RAM_WORDS);
   assign isTxData       = (addr[31:2] == 30'h3FFF_C000);
   assign isStatus       = (addr[31:2] == 30'h3FFF_C001);
   assign isCycles       = (addr[31:2] == 30'h3FFF_C002);
   assign ramIdx         = addr[RAM_AW+1:2];
   assign unusedAddrBits = ^addr[1:0];

   logic [31:0] ramMem [RAM_WORDS];

   always_ff @(posedge clk) begin
      if (memwrite && isRam) begin
         ramMem[ramIdx] <= writedata;
      end
   end

   logic [31:0] cycleReg;

   always_ff @(posedge clk) begin
      if (reset) begin
         cycleReg <= '0;
      end else if (memwrite && isCycles) begin
         cycleReg <= writedata;
      end else begin
         cycleReg <= cycleReg + 32'd1;
      end
   end

   // TX byte FIFO; full/empty come from pre-edge state, so a push into a full FIFO is lost
   logic [7:0]       fifoMem [FIFO_DEPTH];
   logic [PTR_W-1:0] wrPtrReg, rdPtrReg;
   logic [PTR_W:0]   countReg;
   logic             overflowReg;
   logic             fifoFull, fifoEmpty, pushReq, pushOk, popEn;

   assign fifoFull  = (countReg == (PTR_W+1)'(FIFO_DEPTH));
   assign fifoEmpty = (countReg == '0);
   assign pushReq   = memwrite && isTxData;
   assign pushOk    = pushReq && !fifoFull;

   always_ff @(posedge clk) begin
      if (pushOk) begin
         fifoMem[wrPtrReg] <= writedata[7:0];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wrPtrReg    <= '0;
         rdPtrReg    <= '0;
         countReg    <= '0;
         overflowReg <= 1'b0;
      end else begin
         if (pushOk) wrPtrReg <= wrPtrReg + PTR_W'(1);
         if (popEn)  rdPtrReg <= rdPtrReg + PTR_W'(1);
         case ({pushOk, popEn})
            2'b10:   countReg <= countReg + (PTR_W+1)'(1);
            2'b01:   countReg <= countReg - (PTR_W+1)'(1);
            default: countReg <= countReg;
         endcase
         if (pushReq && fifoFull) begin
            overflowReg <= 1'b1;
         end else if (memwrite && isStatus) begin
            overflowReg <= 1'b0;
         end
      end
   end

   txState_t         stateReg, stateNext;
   logic [CNT_W-1:0] clkCntReg;
   logic [2:0]       bitCntReg;
   logic [7:0]       shiftReg;
   logic             parityReg;
   logic             bitDone, txBit;

   assign bitDone = (clkCntReg == CNT_W'(CLKS_PER_BIT - 1));

   always_ff @(posedge clk) begin
      if (reset) stateReg <= IDLE;
      else       stateReg <= stateNext;
   end

   always_comb begin
      stateNext = stateReg;
      case (stateReg)
         IDLE:    if (!fifoEmpty) stateNext = START;
         START:   if (bitDone) stateNext = DATA;
`ifdef UART_PARITY_EN
         DATA:    if (bitDone && bitCntReg == 3'd7) stateNext = PARITY;
         PARITY:  if (bitDone) stateNext = STOP;
`else
         DATA:    if (bitDone && bitCntReg == 3'd7) stateNext = STOP;
`endif
         STOP:    if (bitDone) stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   always_comb begin
      popEn = (stateReg == IDLE) && !fifoEmpty;
      txBit = 1'b1;
      case (stateReg)
         START:   txBit = 1'b0;
         DATA:    txBit = shiftReg[0];
`ifdef UART_PARITY_EN
         PARITY:  txBit = parityReg;
`endif
         default: txBit = 1'b1;
      endcase
   end

   // uart_tx lags the state by one cycle, which gives the two-cycle store-to-start latency
   always_ff @(posedge clk) begin
      if (reset) begin
         clkCntReg <= '0;
         bitCntReg <= '0;
         shiftReg  <= '0;
         parityReg <= 1'b0;
         uart_tx   <= 1'b1;
      end else begin
         uart_tx <= txBit;
         if (stateReg == IDLE || bitDone) clkCntReg <= '0;
         else                             clkCntReg <= clkCntReg + CNT_W'(1);
         if (popEn) begin
            shiftReg  <= fifoMem[rdPtrReg];
            parityReg <= ^fifoMem[rdPtrReg];
         end else if (stateReg == DATA && bitDone) begin
            shiftReg  <= {1'b0, shiftReg[7:1]};
            bitCntReg <= bitCntReg + 3'd1;
         end
      end
   end

   logic [31:0] statusWord;

   assign statusWord = {16'h0, 8'(countReg), 3'b000, PARITY_FLAG, overflowReg,
                        (stateReg != IDLE), fifoEmpty, fifoFull};

   always_comb begin
      readdata = '0;
      if (isRam)         readdata = ramMem[ramIdx];
      else if (isStatus) readdata = statusWord;
      else if (isCycles) readdata = cycleReg;
   end
endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Bench for dmem_mmio_responder: queue/arithmetic reference model checked every cycle, plus directed literals.
module tb_dmem_mmio_responder;
   localparam int C  = 4;
   localparam int FD = 8;
   localparam int RW = 256;
`ifdef UART_PARITY_EN
   localparam int          FRAME = 11 * C;
   localparam logic [31:0] PAR   = 32'h10;
`else
   localparam int          FRAME = 10 * C;
   localparam logic [31:0] PAR   = 32'h0;
`endif
   localparam logic [31:0] TXD  = 32'hFFFF_0000;
   localparam logic [31:0] STAT = 32'hFFFF_0004;
   localparam logic [31:0] CYC  = 32'hFFFF_0008;

   logic        clk = 1'b0;
   logic        reset, memwrite;
   logic [31:0] addr, writedata, readdata;
   logic        uart_tx;

   always #5 clk = ~clk;

   dmem_mmio_responder #(.RAM_WORDS(RW), .FIFO_DEPTH(FD), .CLKS_PER_BIT(C)) dut (
      .clk(clk), .reset(reset), .memwrite(memwrite), .addr(addr),
      .writedata(writedata), .readdata(readdata), .uart_tx(uart_tx)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Reference model: FIFO as a queue, transmitter as "busy until edge busyEnd"
   logic [7:0]  mq[$];
   logic [31:0] mRam [int];
   logic [31:0] mCyc = 0;
   bit          mOvf = 0;
   bit          started = 0;
   bit          frameActive = 0;
   int          k = 0;
   int          busyEnd = 0;
   int          popEdge = 0;
   logic [7:0]  popByte = 0;

   function automatic bit ramHit(input logic [31:0] a);
      return (a[31:16] == 16'h0) && ((a >> 2) < RW);
   endfunction

   task automatic modelStep();
      bit full;
      logic [31:0] w;
      k++;
      w = addr & 32'hFFFF_FFFC;
      if (reset) begin
         mq.delete();
         mOvf = 0;
         mCyc = 0;
         busyEnd = k;
         frameActive = 0;
         started = 1;
      end else begin
         full = (mq.size() == FD);
         if (k > busyEnd && mq.size() != 0) begin
            popByte = mq.pop_front();
            popEdge = k;
            frameActive = 1;
            busyEnd = k + FRAME;
         end
         if (memwrite && w == TXD) begin
            if (full) mOvf = 1;
            else mq.push_back(writedata[7:0]);
         end
         if (memwrite && w == STAT) mOvf = 0;
         mCyc = (memwrite && w == CYC) ? writedata : mCyc + 1;
      end
      if (memwrite && ramHit(addr)) mRam[int'(addr >> 2)] = writedata;
   endtask

   function automatic logic [31:0] modelRead(input logic [31:0] a, output bit known);
      logic [31:0] w;
      known = 1;
      w = a & 32'hFFFF_FFFC;
      if (ramHit(a)) begin
         if (mRam.exists(int'(a >> 2))) return mRam[int'(a >> 2)];
         known = 0;
         return 0;
      end
      if (w == STAT)
         return {16'h0, 8'(mq.size()), 3'b000, PAR[4], mOvf, (k < busyEnd),
                 (mq.size() == 0), (mq.size() == FD)};
      if (w == CYC) return mCyc;
      return 0;
   endfunction

   function automatic logic modelTx();
      int slot;
      if (!frameActive || k < popEdge + 1 || k >= popEdge + 1 + FRAME) return 1'b1;
      slot = (k - popEdge - 1) / C;
      if (slot == 0) return 1'b0;
      if (slot <= 8) return popByte[slot-1];
`ifdef UART_PARITY_EN
      if (slot == 9) return ^popByte;
`endif
      return 1'b1;
   endfunction

   initial forever begin
      @(posedge clk);
      modelStep();
   end

   initial forever begin
      bit known;
      logic [31:0] exp;
      @(negedge clk);
      if (started) begin
         exp = modelRead(addr, known);
         if (known) check("model_readdata", readdata, exp);
         check("model_uart_tx", 32'(uart_tx), 32'(modelTx()));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] d);
      memwrite  = we;
      addr      = a;
      writedata = d;
      $display("TXN we=%0d addr=%h data=%h", we, a, d);
      tick();
      memwrite = 1'b0;
   endtask

   task automatic rdCheck(input string name, input logic [31:0] a, input logic [31:0] exp);
      memwrite = 1'b0;
      addr     = a;
      #1;
      check(name, readdata, exp);
   endtask

   // Call right after the TXDATA store edge with addr on STATUS; samples mid-bit
   task automatic checkFrame(input string name, input logic [10:0] expBits);
      repeat (2 + C / 2) tick();
      for (int s = 0; s < FRAME / C; s++) begin
         if (s > 0) repeat (C) tick();
         check($sformatf("%s_slot%0d", name, s), 32'(uart_tx), 32'(expBits[s]));
         check($sformatf("%s_busy%0d", name, s), 32'(readdata[2]), 32'd1);
      end
      repeat (C) tick();
      check({name, "_idle_tx"}, 32'(uart_tx), 32'd1);
      check({name, "_idle_busy"}, 32'(readdata[2]), 32'd0);
   endtask

   initial begin
      bit sawLow;
      reset = 1'b1; memwrite = 1'b0; addr = '0; writedata = '0;
      repeat (3) tick();
      reset = 1'b0;
      check("reset_tx", 32'(uart_tx), 32'd1);
      rdCheck("reset_status", STAT, 32'h2 | PAR);

      drive(1, 32'h10, 32'hDEAD_BEEF);
      rdCheck("ram_rd", 32'h10, 32'hDEAD_BEEF);
      rdCheck("unmapped_400", 32'h400, 32'h0);
      memwrite = 1'b1; addr = 32'h10; writedata = 32'h1234_5678;
      #1;
      check("ram_old_during_wr", readdata, 32'hDEAD_BEEF);
      tick();
      memwrite = 1'b0;
      rdCheck("ram_new", 32'h10, 32'h1234_5678);
      drive(1, 32'h3FC, 32'hA5A5_0001);
      rdCheck("ram_top", 32'h3FC, 32'hA5A5_0001);
      drive(1, 32'h0001_0010, 32'hBAD0_BAD0);
      rdCheck("ram_no_alias_hi", 32'h10, 32'h1234_5678);
      rdCheck("unmapped_hi", 32'h0001_0010, 32'h0);
      drive(1, 32'h0, 32'h1111_1111);
      drive(1, 32'h400, 32'hBAD1_BAD1);
      rdCheck("ram_no_alias_400", 32'h0, 32'h1111_1111);

      drive(1, TXD, 32'h55);
      addr = STAT;
`ifdef UART_PARITY_EN
      checkFrame("b55", 11'h4AA);
`else
      checkFrame("b55", 11'h2AA);
`endif

      drive(1, TXD, 32'hA0);
      repeat (3) tick();
      for (int i = 1; i <= 9; i++) drive(1, TXD, 32'(i));
      rdCheck("ovf_status", STAT, 32'h0000_080D | PAR);
      drive(1, STAT, 32'h0);
      rdCheck("ovf_clear", STAT, 32'h0000_0805 | PAR);
      repeat (9 * (FRAME + 1) + 10) tick();
      rdCheck("drained", STAT, 32'h2 | PAR);

      drive(1, CYC, 32'hFFFF_FFFE);
      rdCheck("cyc0", CYC, 32'hFFFF_FFFE);
      tick();
      check("cyc1", readdata, 32'hFFFF_FFFF);
      tick();
      check("cyc2", readdata, 32'h0);
      tick();
      check("cyc3", readdata, 32'h1);

`ifdef UART_PARITY_EN
      drive(1, TXD, 32'h07);
      addr = STAT;
      checkFrame("b07", 11'h60E);
      drive(1, TXD, 32'h03);
      addr = STAT;
      checkFrame("b03", 11'h406);
`endif

      for (int i = 0; i < 4; i++) drive(1, TXD, 32'hC0 + 32'(i));
      addr = STAT;
      repeat (2 + 4 * C) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("rst_mid_tx", 32'(uart_tx), 32'd1);
      rdCheck("rst_mid_status", STAT, 32'h2 | PAR);
      sawLow = 0;
      repeat (2 * FRAME) begin
         tick();
         if (uart_tx !== 1'b1) sawLow = 1;
      end
      check("rst_no_start", 32'(sawLow), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      errors++;
      $display("FAIL timeout actual=running expected=finished");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
